counter_event_log: RTL and testbench
====================================

# counter_event_log

Timestamped event recorder on `sys_clk`, downstream of the counter block. It detects rising edges on the counter's compare-flag outputs (e.g. count-equals-00/80/FF) and packs each edge set with a free-running 24-bit timestamp into a 32-bit entry. Entries are buffered in a small FIFO and drained one word per read strobe, sized for a host wire-out/trigger-in pair. Events from one cycle are never split across entries, and overflow is reported rather than silent.

## Interface
Parameters:
- `N_EVT`, 4: number of event inputs, 1..4.
- `DEPTH`, 16: FIFO entries, power of two, 4..256.
- `WRAP_MARK`, 1: when 1, a timestamp wrap writes a marker entry.

Ports:
- `sys_clk`  in  1: single clock; all logic on rising edge.
- `reset`  in  1: synchronous, active-high.
- `evt_in`  in  N_EVT: level event flags, synchronous to `sys_clk`.
- `rd_en`  in  1: one-cycle read strobe.
- `clear`  in  1: synchronous flush of FIFO and sticky flags; timestamp keeps running.
- `dout`  out  32: last read entry.
- `dout_valid`  out  1: one-cycle pulse, `dout` updated.
- `empty`  out  1: FIFO empty.
- `full`  out  1: FIFO full.
- `level`  out  clog2(DEPTH)+1: entries held.
- `overflow`  out  1: sticky, at least one entry dropped.

## Operation
- Entry format:
  - [31:28] event mask (bit i = rising edge on `evt_in[i]`; unused bits 0).
  - [27] lost: one or more entries were dropped immediately before this one.
  - [26] wrap marker.
  - [25:24] 0.
  - [23:0] timestamp.
- Edge detect: `evt_q` <= `evt_in`; rise = `evt_in & ~evt_q`. Any nonzero rise in a cycle produces exactly one entry containing all simultaneous edges.
- Timestamp `ts` increments every cycle and wraps FFFFFF->000000. An entry carries the `ts` value at the write edge, before the increment.
- Wrap marker: the cycle `ts`==FFFFFF with WRAP_MARK=1 requests an entry with bit 26 set and timestamp FFFFFF. It merges with any event rise in the same cycle into one entry.
- Full: a write request while full, with no accepted read that cycle, is dropped. Dropping sets `overflow` and an internal `pending_lost`. The next accepted write carries lost=1 and clears `pending_lost`.
- Simultaneous read and write while full: the read frees a slot and the write is accepted; `level` is unchanged and no overflow occurs.
- Read while empty is ignored: no `dout_valid`, and `dout` holds its value.
- `clear`:
  - Resets pointers, `level`, `overflow` and `pending_lost`.
  - Writes and reads in the same cycle are discarded.
  - `evt_q` still updates, so no spurious edges follow.

## Timing
- Event latency: a rise sampled at edge k writes the entry at edge k. `empty` deasserts and `level` increments after edge k.
- Read latency: `rd_en` sampled high at edge k with `empty`=0. `dout` and `dout_valid`=1 appear after edge k, and `dout_valid` drops after edge k+1.
- Back-to-back reads every cycle are supported.
- Reset values:
  - `dout`=0, `dout_valid`=0.
  - `empty`=1, `full`=0, `level`=0, `overflow`=0.
  - `ts`=0, `pending_lost`=0.
  - `evt_q` = all ones, so flags already high at reset release are not logged.
- Reset mid-operation: all state returns to reset values on the same edge, and buffered entries are lost.
- `reset` has priority over `clear`.

## Structure
- Shared package `counter_event_pkg`:
  - Field position constants `EVT_MSB/LSB`, `LOST_BIT`, `WRAP_BIT`, `TS_MSB/LSB`.
  - `TS_W`=24 and `ENTRY_W`=32.
- Sub-module `event_fifo`:
  - Synchronous FIFO, parameters `WIDTH` and `DEPTH`.
  - Registered read data; wr/rd/clear inputs.
  - full/empty/level outputs.
- Top level holds edge detection, timestamp, wrap request, lost tracking and entry packing.

## Test plan
- Reset, then `evt_in`=0001 at cycle 10 -> one entry with mask 0001, lost=0, ts=000009 (ts counted from 0 at first post-reset edge). Read -> `dout`=1000_0009 one cycle after `rd_en`, `empty`=1 afterwards.
- `evt_in` bits 0 and 2 rise in the same cycle -> a single entry with mask 0101. `evt_in` held high for 50 cycles -> no further entries.
- DEPTH=16: 18 separate rises with no reads -> `full`=1, `level`=16, `overflow`=1. After one read and one new rise, the 17th stored entry has bit 27 set.
- Full FIFO with `rd_en` and a rise in the same cycle -> `level` stays 16 and `overflow` stays 0.
- Preload `ts` near wrap, e.g. a long run to FFFFFF with WRAP_MARK=1 and a rise in that cycle -> one entry with mask set, bit 26 set, ts=FFFFFF. The next entry's ts is small.
- `evt_in`=1 during reset and at release -> no entry. `clear` with 5 entries held -> `empty`=1, `overflow`=0. `rd_en` on empty -> no `dout_valid`.

Source files
------------

// File: rtl/counter_event_pkg.sv
// Shared entry layout for the counter event log: field positions, widths and the packing helper.
package counter_event_pkg;

    localparam int TS_W     = 24;
    localparam int ENTRY_W  = 32;
    localparam int EVT_W    = 4;

    localparam int EVT_MSB  = 31;
    localparam int EVT_LSB  = 28;
    localparam int LOST_BIT = 27;
    localparam int WRAP_BIT = 26;
    localparam int TS_MSB   = 23;
    localparam int TS_LSB   = 0;

    function automatic logic [ENTRY_W-1:0] pack_entry(
        input logic [EVT_W-1:0] mask,
        input logic             lost,
        input logic             wrap,
        input logic [TS_W-1:0]  ts
    );
        logic [ENTRY_W-1:0] e;
        e                   = '0;
        e[EVT_MSB:EVT_LSB]  = mask;
        e[LOST_BIT]         = lost;
        e[WRAP_BIT]         = wrap;
        e[TS_MSB:TS_LSB]    = ts;
        return e;
    endfunction

endpackage

// File: rtl/event_fifo.sv
// Synchronous FIFO with registered read data; a write while full is accepted only if a read frees a slot the same cycle.
// clear flushes pointers and level and discards that cycle's read/write; read data holds its last value.
module event_fifo #(
    parameter int WIDTH = 32,
    parameter int DEPTH = 16
) (
    input  logic                   i_clk,
    input  logic                   i_reset,
    input  logic                   i_clear,
    input  logic                   i_wr_en,
    input  logic [WIDTH-1:0]       i_wr_dat,
    input  logic                   i_rd_en,
    output logic [WIDTH-1:0]       o_rd_dat,
    output logic                   o_rd_vld,
    output logic                   o_empty,
    output logic                   o_full,
    output logic [$clog2(DEPTH):0] o_level
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] FULL_LVL = DEPTH[AW:0];

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [AW-1:0]    r_wr_ptr;
    logic [AW-1:0]    r_rd_ptr;
    logic [AW:0]      r_level;
    logic [WIDTH-1:0] r_rd_dat;
    logic             r_rd_vld;
    logic             w_rd_acc;
    logic             w_wr_acc;

    assign o_empty  = (r_level == '0);
    assign o_full   = (r_level == FULL_LVL);
    assign o_level  = r_level;
    assign o_rd_dat = r_rd_dat;
    assign o_rd_vld = r_rd_vld;

    assign w_rd_acc = i_rd_en && !o_empty && !i_clear;
    // When full, the slot being read this cycle is the one the write lands in.
    assign w_wr_acc = i_wr_en && !i_clear && (!o_full || w_rd_acc);

    always_ff @(posedge i_clk) begin
        if (w_wr_acc) begin
            r_mem[r_wr_ptr] <= i_wr_dat;
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_level  <= '0;
            r_rd_dat <= '0;
            r_rd_vld <= 1'b0;
        end else if (i_clear) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_level  <= '0;
            r_rd_vld <= 1'b0;
        end else begin
            r_rd_vld <= w_rd_acc;
            if (w_wr_acc) begin
                r_wr_ptr <= r_wr_ptr + AW'(1);
            end
            if (w_rd_acc) begin
                r_rd_ptr <= r_rd_ptr + AW'(1);
                r_rd_dat <= r_mem[r_rd_ptr];
            end
            if (w_wr_acc && !w_rd_acc) begin
                r_level <= r_level + (AW+1)'(1);
            end else if (!w_wr_acc && w_rd_acc) begin
                r_level <= r_level - (AW+1)'(1);
            end
        end
    end

endmodule

// File: rtl/counter_event_log.sv
// Timestamped event recorder: rising edges on evt_in (plus an optional ts-wrap marker) become one 32-bit entry per cycle.
// Entries that find the FIFO full are dropped, flagged as sticky overflow and as lost on the next stored entry.
module counter_event_log
    import counter_event_pkg::*;
#(
    parameter int              N_EVT     = 4,
    parameter int              DEPTH     = 16,
    parameter int              WRAP_MARK = 1,
    // Reset value of the timestamp; 0 in normal use.
    parameter logic [TS_W-1:0] TS_INIT   = '0
) (
    input  logic                   sys_clk,
    input  logic                   reset,
    input  logic [N_EVT-1:0]       evt_in,
    input  logic                   rd_en,
    input  logic                   clear,
    output logic [ENTRY_W-1:0]     dout,
    output logic                   dout_valid,
    output logic                   empty,
    output logic                   full,
    output logic [$clog2(DEPTH):0] level,
    output logic                   overflow
);

    logic [N_EVT-1:0]   r_evt_q;
    logic [TS_W-1:0]    r_ts;
    logic               r_pending_lost;
    logic               r_overflow;

    logic [N_EVT-1:0]   w_rise;
    logic [EVT_W-1:0]   w_mask;
    logic               w_wrap_req;
    logic               w_wr_req;
    logic               w_rd_acc;
    logic               w_wr_acc;
    logic               w_drop;
    logic [ENTRY_W-1:0] w_entry;

    assign w_rise = evt_in & ~r_evt_q;

    always_comb begin
        w_mask              = '0;
        w_mask[N_EVT-1:0]   = w_rise;
    end

    assign w_wrap_req = (WRAP_MARK != 0) && (r_ts == '1);
    assign w_wr_req   = (|w_rise) || w_wrap_req;
    assign w_rd_acc   = rd_en && !empty && !clear;
    assign w_wr_acc   = w_wr_req && !clear && (!full || w_rd_acc);
    assign w_drop     = w_wr_req && !clear && full && !w_rd_acc;
    assign w_entry    = pack_entry(w_mask, r_pending_lost, w_wrap_req, r_ts);

    // evt_q resets high so flags already asserted when reset releases do not log.
    always_ff @(posedge sys_clk) begin
        if (reset) begin
            r_evt_q        <= '1;
            r_ts           <= TS_INIT;
            r_pending_lost <= 1'b0;
            r_overflow     <= 1'b0;
        end else begin
            r_evt_q <= evt_in;
            r_ts    <= r_ts + TS_W'(1);
            if (clear) begin
                r_pending_lost <= 1'b0;
                r_overflow     <= 1'b0;
            end else if (w_drop) begin
                r_pending_lost <= 1'b1;
                r_overflow     <= 1'b1;
            end else if (w_wr_acc) begin
                r_pending_lost <= 1'b0;
            end
        end
    end

    assign overflow = r_overflow;

    event_fifo #(
        .WIDTH (ENTRY_W),
        .DEPTH (DEPTH)
    ) u_fifo (
        .i_clk    (sys_clk),
        .i_reset  (reset),
        .i_clear  (clear),
        .i_wr_en  (w_wr_acc),
        .i_wr_dat (w_entry),
        .i_rd_en  (rd_en),
        .o_rd_dat (dout),
        .o_rd_vld (dout_valid),
        .o_empty  (empty),
        .o_full   (full),
        .o_level  (level)
    );

endmodule

// File: tb/tb_counter_event_log.sv
// Bench for counter_event_log: directed scenarios plus randomized traffic checked against a queue-based model.
module tb_counter_event_log;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [3:0]  evt = 4'b0;
    logic        rd_en = 1'b0;
    logic        clr = 1'b0;
    logic [31:0] dout;
    logic        dv;
    logic        empty;
    logic        full;
    logic [4:0]  level;
    logic        ovf;

    logic        rst_w = 1'b1;
    logic [3:0]  evt_w = 4'b0;
    logic        rd_w = 1'b0;
    logic        clr_w = 1'b0;
    logic [31:0] dout_w;
    logic        dv_w;
    logic        empty_w;
    logic        full_w;
    logic [4:0]  level_w;
    logic        ovf_w;

    int n_cmp = 0;
    int n_err = 0;

    // Reference model state
    logic [31:0] m_q[$];
    logic [23:0] m_ts;
    logic [3:0]  m_prev;
    logic        m_ovf;
    logic        m_pend;
    logic [31:0] m_dout;
    logic        m_dv;

    always #5 clk = ~clk;

    counter_event_log #(.N_EVT(4), .DEPTH(16), .WRAP_MARK(1)) dut (
        .sys_clk(clk), .reset(rst), .evt_in(evt), .rd_en(rd_en), .clear(clr),
        .dout(dout), .dout_valid(dv), .empty(empty), .full(full), .level(level), .overflow(ovf)
    );

    counter_event_log #(.N_EVT(4), .DEPTH(16), .WRAP_MARK(1), .TS_INIT(24'hFFFFE0)) dut_w (
        .sys_clk(clk), .reset(rst_w), .evt_in(evt_w), .rd_en(rd_w), .clear(clr_w),
        .dout(dout_w), .dout_valid(dv_w), .empty(empty_w), .full(full_w), .level(level_w), .overflow(ovf_w)
    );

    // Applies the rules to the inputs presented this cycle, then advances one clock.
    task automatic tick();
        logic [3:0] rise;
        logic       wrap;
        if (rst) begin
            m_q.delete();
            m_ts   = '0;
            m_prev = '1;
            m_ovf  = 1'b0;
            m_pend = 1'b0;
            m_dout = '0;
            m_dv   = 1'b0;
        end else begin
            rise   = evt & ~m_prev;
            m_prev = evt;
            m_dv   = 1'b0;
            wrap   = (m_ts == 24'hFFFFFF);
            if (clr) begin
                m_q.delete();
                m_ovf  = 1'b0;
                m_pend = 1'b0;
            end else begin
                if (rd_en && m_q.size() != 0) begin
                    m_dout = m_q.pop_front();
                    m_dv   = 1'b1;
                end
                if (rise != 4'b0 || wrap) begin
                    if (m_q.size() < 16) begin
                        m_q.push_back({rise, m_pend, wrap, 2'b00, m_ts});
                        m_pend = 1'b0;
                    end else begin
                        m_ovf  = 1'b1;
                        m_pend = 1'b1;
                    end
                end
            end
            m_ts = m_ts + 24'd1;
        end
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b1; evt = 4'b1111; rd_en = 1'b0; clr = 1'b0;
        repeat (3) tick();
        n_cmp++; if (dout !== 32'h0) begin n_err++; $display("FAIL reset_dout: got %h want 00000000", dout); end
        n_cmp++; if (dv !== 1'b0) begin n_err++; $display("FAIL reset_dout_valid: got %b want 0", dv); end
        n_cmp++; if (empty !== 1'b1) begin n_err++; $display("FAIL reset_empty: got %b want 1", empty); end
        n_cmp++; if (full !== 1'b0) begin n_err++; $display("FAIL reset_full: got %b want 0", full); end
        n_cmp++; if (level !== 5'd0) begin n_err++; $display("FAIL reset_level: got %0d want 0", level); end
        n_cmp++; if (ovf !== 1'b0) begin n_err++; $display("FAIL reset_overflow: got %b want 0", ovf); end
        rst = 1'b0;
        repeat (4) tick();
        n_cmp++; if (level !== 5'd0) begin n_err++; $display("FAIL high_at_release_level: got %0d want 0", level); end
        evt = 4'b0;
        tick();
    endtask

    task automatic test_first_event();
        rst = 1'b1; evt = 4'b0;
        repeat (2) tick();
        rst = 1'b0;
        repeat (9) tick();
        evt = 4'b0001;
        tick();
        n_cmp++; if (level !== 5'd1) begin n_err++; $display("FAIL first_level: got %0d want 1", level); end
        n_cmp++; if (empty !== 1'b0) begin n_err++; $display("FAIL first_empty: got %b want 0", empty); end
        rd_en = 1'b1;
        tick();
        rd_en = 1'b0;
        n_cmp++; if (dv !== 1'b1) begin n_err++; $display("FAIL first_dout_valid: got %b want 1", dv); end
        n_cmp++; if (dout !== 32'h10000009) begin n_err++; $display("FAIL first_dout: got %h want 10000009", dout); end
        n_cmp++; if (dout !== m_dout) begin n_err++; $display("FAIL first_dout_model: got %h want %h", dout, m_dout); end
        n_cmp++; if (empty !== 1'b1) begin n_err++; $display("FAIL first_empty_after: got %b want 1", empty); end
        tick();
        n_cmp++; if (dv !== 1'b0) begin n_err++; $display("FAIL first_dout_valid_drop: got %b want 0", dv); end
    endtask

    task automatic test_simultaneous();
        evt = 4'b0;
        tick();
        evt = 4'b0101;
        tick();
        n_cmp++; if (level !== 5'd1) begin n_err++; $display("FAIL simul_level: got %0d want 1", level); end
        repeat (50) tick();
        n_cmp++; if (level !== 5'd1) begin n_err++; $display("FAIL held_level: got %0d want 1", level); end
        rd_en = 1'b1;
        tick();
        rd_en = 1'b0;
        n_cmp++; if (dout[31:28] !== 4'b0101) begin n_err++; $display("FAIL simul_mask: got %b want 0101", dout[31:28]); end
        n_cmp++; if (dout !== m_dout) begin n_err++; $display("FAIL simul_dout_model: got %h want %h", dout, m_dout); end
        evt = 4'b0;
        tick();
    endtask

    task automatic test_full_rw();
        clr = 1'b1;
        tick();
        clr = 1'b0;
        for (int i = 0; i < 16; i++) begin
            evt = 4'b0010; tick();
            evt = 4'b0000; tick();
        end
        n_cmp++; if (full !== 1'b1) begin n_err++; $display("FAIL frw_full: got %b want 1", full); end
        n_cmp++; if (ovf !== 1'b0) begin n_err++; $display("FAIL frw_ovf_before: got %b want 0", ovf); end
        rd_en = 1'b1; evt = 4'b0010;
        tick();
        rd_en = 1'b0; evt = 4'b0;
        n_cmp++; if (level !== 5'd16) begin n_err++; $display("FAIL frw_level: got %0d want 16", level); end
        n_cmp++; if (ovf !== 1'b0) begin n_err++; $display("FAIL frw_ovf: got %b want 0", ovf); end
        n_cmp++; if (dv !== 1'b1) begin n_err++; $display("FAIL frw_dout_valid: got %b want 1", dv); end
        tick();
    endtask

    task automatic test_overflow();
        clr = 1'b1;
        tick();
        clr = 1'b0;
        for (int i = 0; i < 18; i++) begin
            evt = 4'b1000; tick();
            evt = 4'b0000; tick();
        end
        n_cmp++; if (full !== 1'b1) begin n_err++; $display("FAIL ovf_full: got %b want 1", full); end
        n_cmp++; if (level !== 5'd16) begin n_err++; $display("FAIL ovf_level: got %0d want 16", level); end
        n_cmp++; if (ovf !== 1'b1) begin n_err++; $display("FAIL ovf_flag: got %b want 1", ovf); end
        rd_en = 1'b1;
        tick();
        rd_en = 1'b0; evt = 4'b1000;
        tick();
        evt = 4'b0;
        for (int i = 0; i < 16; i++) begin
            rd_en = 1'b1;
            tick();
            n_cmp++; if (dout !== m_dout) begin n_err++; $display("FAIL ovf_drain_%0d: got %h want %h", i, dout, m_dout); end
            n_cmp++; if (dout[27] !== (i == 15)) begin n_err++; $display("FAIL ovf_lost_bit_%0d: got %b want %b", i, dout[27], (i == 15)); end
        end
        rd_en = 1'b0;
        tick();
        n_cmp++; if (ovf !== 1'b1) begin n_err++; $display("FAIL ovf_sticky: got %b want 1", ovf); end
        n_cmp++; if (empty !== 1'b1) begin n_err++; $display("FAIL ovf_drained_empty: got %b want 1", empty); end
    endtask

    task automatic test_clear();
        logic [31:0] held;
        for (int i = 0; i < 5; i++) begin
            evt = 4'b0100; tick();
            evt = 4'b0000; tick();
        end
        n_cmp++; if (level !== 5'd5) begin n_err++; $display("FAIL clr_level_before: got %0d want 5", level); end
        clr = 1'b1; evt = 4'b0001;
        tick();
        clr = 1'b0;
        n_cmp++; if (empty !== 1'b1) begin n_err++; $display("FAIL clr_empty: got %b want 1", empty); end
        n_cmp++; if (ovf !== 1'b0) begin n_err++; $display("FAIL clr_ovf: got %b want 0", ovf); end
        n_cmp++; if (level !== 5'd0) begin n_err++; $display("FAIL clr_level: got %0d want 0", level); end
        tick();
        n_cmp++; if (level !== 5'd0) begin n_err++; $display("FAIL clr_no_spurious: got %0d want 0", level); end
        held = m_dout;
        rd_en = 1'b1;
        tick();
        rd_en = 1'b0; evt = 4'b0;
        n_cmp++; if (dv !== 1'b0) begin n_err++; $display("FAIL empty_read_valid: got %b want 0", dv); end
        n_cmp++; if (dout !== held) begin n_err++; $display("FAIL empty_read_dout: got %h want %h", dout, held); end
        tick();
    endtask

    task automatic test_wrap();
        rst_w = 1'b1; evt_w = 4'b0; rd_w = 1'b0; clr_w = 1'b0;
        repeat (2) tick();
        rst_w = 1'b0;
        repeat (31) tick();
        n_cmp++; if (level_w !== 5'd0) begin n_err++; $display("FAIL wrap_pre_level: got %0d want 0", level_w); end
        evt_w = 4'b0001;
        tick();
        n_cmp++; if (level_w !== 5'd1) begin n_err++; $display("FAIL wrap_merge_level: got %0d want 1", level_w); end
        evt_w = 4'b0;
        tick();
        evt_w = 4'b0001;
        tick();
        evt_w = 4'b0;
        n_cmp++; if (level_w !== 5'd2) begin n_err++; $display("FAIL wrap_level: got %0d want 2", level_w); end
        rd_w = 1'b1;
        tick();
        n_cmp++; if (dout_w !== 32'h14FFFFFF) begin n_err++; $display("FAIL wrap_entry: got %h want 14FFFFFF", dout_w); end
        n_cmp++; if (dv_w !== 1'b1) begin n_err++; $display("FAIL wrap_dout_valid: got %b want 1", dv_w); end
        tick();
        rd_w = 1'b0;
        n_cmp++; if (dout_w !== 32'h10000001) begin n_err++; $display("FAIL wrap_next_entry: got %h want 10000001", dout_w); end
        n_cmp++; if (empty_w !== 1'b1) begin n_err++; $display("FAIL wrap_empty: got %b want 1", empty_w); end
        n_cmp++; if ({full_w, ovf_w} !== 2'b00) begin n_err++; $display("FAIL wrap_full_ovf: got %b want 00", {full_w, ovf_w}); end
        tick();
    endtask

    task automatic test_random();
        for (int i = 0; i < 1500; i++) begin
            evt   = 4'($urandom);
            rd_en = ($urandom_range(0, 9) < 4);
            clr   = ($urandom_range(0, 99) == 0);
            rst   = ($urandom_range(0, 499) == 0);
            tick();
            n_cmp++; if (dv !== m_dv) begin n_err++; $display("FAIL rnd_dout_valid@%0d: got %b want %b", i, dv, m_dv); end
            n_cmp++; if (dout !== m_dout) begin n_err++; $display("FAIL rnd_dout@%0d: got %h want %h", i, dout, m_dout); end
            n_cmp++; if (level !== 5'(m_q.size())) begin n_err++; $display("FAIL rnd_level@%0d: got %0d want %0d", i, level, m_q.size()); end
            n_cmp++; if (empty !== (m_q.size() == 0)) begin n_err++; $display("FAIL rnd_empty@%0d: got %b want %b", i, empty, (m_q.size() == 0)); end
            n_cmp++; if (full !== (m_q.size() == 16)) begin n_err++; $display("FAIL rnd_full@%0d: got %b want %b", i, full, (m_q.size() == 16)); end
            n_cmp++; if (ovf !== m_ovf) begin n_err++; $display("FAIL rnd_overflow@%0d: got %b want %b", i, ovf, m_ovf); end
        end
        rst = 1'b0; clr = 1'b0; rd_en = 1'b0; evt = 4'b0;
        tick();
    endtask

    initial begin
        test_reset();
        test_first_event();
        test_simultaneous();
        test_full_rw();
        test_overflow();
        test_clear();
        test_wrap();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
